// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit cache-line to 64-bit four-beat burst memory adaptor
// One line transaction at a time; a simultaneous read and write request services the write first.
module cacheline_adaptor (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [31:0]  mem_address,
   input  logic [255:0] mem_wdata,
   input  logic         mem_read,
   input  logic         mem_write,
   output logic [255:0] mem_rdata,
   output logic         mem_resp,
   output logic [31:0]  burst_address,
   output logic         burst_read,
   output logic         burst_write,
   output logic [63:0]  burst_wdata,
   input  logic [63:0]  burst_rdata,
   input  logic         burst_resp
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

   state_e         state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [31:0]    addr_q, addr_d;
   logic [255:0]   line_q, line_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         addr_q  <= 32'd0;
         line_q  <= 256'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         line_q  <= line_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      line_d  = line_q;
      case (state_q)
         IDLE: begin
            // Write wins so a dirty victim is written back before its refill.
            if (mem_write) begin
               addr_d  = mem_address;
               line_d  = mem_wdata;
               cnt_d   = 2'd0;
               state_d = WRITE;
            end else if (mem_read) begin
               addr_d  = mem_address;
               cnt_d   = 2'd0;
               state_d = READ;
            end
         end
         READ: begin
            if (burst_resp) begin
               line_d[{cnt_q, 6'd0} +: 64] = burst_rdata;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = DONE;
            end
         end
         WRITE: begin
            if (burst_resp) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_rdata     = line_q;
   assign mem_resp      = (state_q == DONE);
   assign burst_address = {addr_q[31:5], 5'd0};
   assign burst_read    = (state_q == READ);
   assign burst_write   = (state_q == WRITE);
   assign burst_wdata   = (state_q == WRITE) ? line_q[{cnt_q, 6'd0} +: 64] : 64'd0;

endmodule
